// File: rtl/io_bus_arbiter_pkg.sv
// Shared types and sizing helpers for the IO bus arbiter.
// Holds the access-sequencing states and counter/index width functions.
package io_bus_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    ACK    = 3'd4
  } io_bus_state_e;

  localparam int DEFAULT_STROBE_CYCLES = 1;

  function automatic int strobe_cnt_w(input int strobe_cycles);
    return $clog2(strobe_cycles + 1);
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int STROBE_CNT_W = strobe_cnt_w(DEFAULT_STROBE_CYCLES);

endpackage

// File: rtl/io_bus_arbiter_if.sv
// Bus bundle between the requesting masters, the arbiter and the IO block.
// Handshake: a master raises m_req (with m_we/m_addr/m_wdata stable) and holds it until a
// one-cycle m_ack; m_rdata is valid in the m_ack cycle. The IO block read is combinational.
interface io_bus_arbiter_if
  import io_bus_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int NUM_MASTERS = 2
);

  logic [NUM_MASTERS-1:0]            m_req;
  logic [NUM_MASTERS-1:0]            m_we;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr;
  logic [NUM_MASTERS-1:0]            m_wdata;
  logic [NUM_MASTERS-1:0]            m_ack;
  logic                              m_rdata;
  logic [NUM_MASTERS-1:0]            m_grant;
  logic [ADDR_WIDTH-1:0]             io_address;
  logic                              io_write;
  logic                              io_data_in;
  logic                              io_data_out;

  modport slave (
    input  m_req, m_we, m_addr, m_wdata, io_data_out,
    output m_ack, m_rdata, m_grant, io_address, io_write, io_data_in
  );

  modport master (
    output m_req, m_we, m_addr, m_wdata, io_data_out,
    input  m_ack, m_rdata, m_grant, io_address, io_write, io_data_in
  );

endinterface

// File: rtl/io_bus_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer, wrapping.
// Produces a one-hot grant, its index, and a valid flag when any request is present.
module rr_arbiter
  import io_bus_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!valid_o && req_i[(int'(ptr_i) + k) % N]) begin
        valid_o                          = 1'b1;
        grant_o[(int'(ptr_i) + k) % N]   = 1'b1;
        idx_o                            = IDX_W'((int'(ptr_i) + k) % N);
      end
    end
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Arbitrates NUM_MASTERS requesters onto the single-ported IO block, sequencing one
// 1-bit access per grant with a registered, glitch-free write strobe.
module io_bus_arbiter
  import io_bus_pkg::*;
#(
  parameter int ADDR_WIDTH    = 8,
  parameter int NUM_MASTERS   = 2,
  parameter int STROBE_CYCLES = DEFAULT_STROBE_CYCLES
) (
  input  logic           clk,
  input  logic           reset,
  io_bus_arbiter_if.slave bus,
  output io_bus_state_e  state_o
);

  localparam int IDX_W = idx_w(NUM_MASTERS);
  localparam int CNT_W = strobe_cnt_w(STROBE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_MASTERS - 1);

  io_bus_state_e          state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       gidx_q, gidx_d;
  logic [IDX_W-1:0]       rr_q, rr_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   we_q, we_d;
  logic                   wdata_q, wdata_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rdata_q, rdata_d;
  logic                   io_write_q, io_write_d;

  logic [NUM_MASTERS-1:0] arb_grant;
  logic [IDX_W-1:0]       arb_idx;
  logic                   arb_valid;

  rr_arbiter #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req_i   (bus.m_req),
    .ptr_i   (rr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // io_write_d is the strobe value for the *next* state, so io_write is a flop output.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    rr_d       = rr_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    io_write_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d = arb_grant;
          gidx_d  = arb_idx;
          addr_d  = bus.m_addr[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          we_d    = bus.m_we[arb_idx];
          wdata_d = bus.m_wdata[arb_idx];
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d      = '0;
        io_write_d = we_q;
        state_d    = STROBE;
      end
      STROBE: begin
        if (cnt_q == CNT_LAST) begin
          if (!we_q) begin
            rdata_d = bus.io_data_out;
          end
          state_d = HOLD;
        end else begin
          cnt_d      = cnt_q + CNT_W'(1);
          io_write_d = we_q;
        end
      end
      HOLD: begin
        state_d = ACK;
      end
      ACK: begin
        rr_d    = (gidx_q == IDX_LAST) ? '0 : gidx_q + IDX_W'(1);
        grant_d = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_q       <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= 1'b0;
      cnt_q      <= '0;
      rdata_q    <= 1'b0;
      io_write_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      rr_q       <= rr_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      io_write_q <= io_write_d;
    end
  end

  assign bus.m_ack      = (state_q == ACK) ? grant_q : '0;
  assign bus.m_rdata    = rdata_q;
  assign bus.m_grant    = grant_q;
  assign bus.io_address = addr_q;
  assign bus.io_write   = io_write_q;
  assign bus.io_data_in = wdata_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter: one instance with 1-cycle strobe, one with 3-cycle strobe,
// each attached to a small behavioural IO block (RAM, output latches, input pins).
module tb_io_bus_arbiter;
  import io_bus_pkg::*;

  localparam int AW          = 8;
  localparam int NM          = 2;
  localparam int OUTPUT_SIZE = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  io_bus_arbiter_if #(.ADDR_WIDTH(AW), .NUM_MASTERS(NM)) if_a ();
  io_bus_arbiter_if #(.ADDR_WIDTH(AW), .NUM_MASTERS(NM)) if_b ();
  io_bus_state_e st_a, st_b;

  io_bus_arbiter #(.ADDR_WIDTH(AW), .NUM_MASTERS(NM), .STROBE_CYCLES(1)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a.slave), .state_o(st_a));
  io_bus_arbiter #(.ADDR_WIDTH(AW), .NUM_MASTERS(NM), .STROBE_CYCLES(3)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b.slave), .state_o(st_b));

  // IO block models: writes land on the rising edge of io_write.
  logic                   ram_a [0:127];
  logic [OUTPUT_SIZE-1:0] out_a;
  logic [OUTPUT_SIZE-1:0] out_b;
  logic [7:0]             in_pins;

  always @(posedge if_a.io_write) begin
    if (if_a.io_address < 8'h80) ram_a[if_a.io_address[6:0]] <= if_a.io_data_in;
    else if (if_a.io_address < 8'h80 + OUTPUT_SIZE) out_a[if_a.io_address[2:0]] <= if_a.io_data_in;
  end

  always_comb begin
    if (if_a.io_address < 8'h80)                    if_a.io_data_out = ram_a[if_a.io_address[6:0]];
    else if (if_a.io_address < 8'h80 + OUTPUT_SIZE) if_a.io_data_out = out_a[if_a.io_address[2:0]];
    else if (if_a.io_address < 8'h90)               if_a.io_data_out = in_pins[if_a.io_address[2:0]];
    else                                            if_a.io_data_out = 1'b0;
  end

  always @(posedge if_b.io_write) begin
    if (if_b.io_address >= 8'h80 && if_b.io_address < 8'h80 + OUTPUT_SIZE)
      out_b[if_b.io_address[2:0]] <= if_b.io_data_in;
  end
  assign if_b.io_data_out = 1'b0;

  int n_vec = 0;
  int n_bad = 0;
  logic [0:0] exp_q [$];

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input int m, input logic req, input logic we,
                       input logic [AW-1:0] addr, input logic wd);
    if (sel == 0) begin
      if_a.m_req[m] = req; if_a.m_we[m] = we; if_a.m_addr[m*AW +: AW] = addr; if_a.m_wdata[m] = wd;
    end else begin
      if_b.m_req[m] = req; if_b.m_we[m] = we; if_b.m_addr[m*AW +: AW] = addr; if_b.m_wdata[m] = wd;
    end
  endtask

  task automatic sample(input int sel, input int m, output logic w, output logic ack,
                        output logic [NM-1:0] gnt, output logic [AW-1:0] addr, output logic rd);
    if (sel == 0) begin
      w = if_a.io_write; ack = if_a.m_ack[m]; gnt = if_a.m_grant; addr = if_a.io_address; rd = if_a.m_rdata;
    end else begin
      w = if_b.io_write; ack = if_b.m_ack[m]; gnt = if_b.m_grant; addr = if_b.io_address; rd = if_b.m_rdata;
    end
  endtask

  // One access from IDLE: cycle 0 = request sampled, ack expected at cycle 3+sc.
  task automatic access(input int sel, input int sc, input int m, input logic we,
                        input logic [AW-1:0] addr, input logic wd, input logic exp_rd,
                        input string tag);
    int ack_cyc = -1;
    int first_w = -1;
    int n_w = 0;
    logic addr_ok = 1'b1;
    logic grant_ok = 1'b1;
    logic w, ack, rd;
    logic [NM-1:0] g;
    logic [AW-1:0] a;
    logic [0:0] exp;
    if (!we) exp_q.push_back(exp_rd);
    drive(sel, m, 1'b1, we, addr, wd);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      sample(sel, m, w, ack, g, a, rd);
      if (w) begin
        n_w++;
        if (first_w < 0) first_w = k;
      end
      if (k >= 1 && k <= 2 + sc && a !== addr) addr_ok = 1'b0;
      if (k >= 1 && k <= 3 + sc && g !== NM'(1 << m)) grant_ok = 1'b0;
      if (ack) begin
        ack_cyc = k;
        if (!we) begin
          exp = exp_q.pop_front();
          check_vec({tag, "_rdata"}, 32'(rd), 32'(exp));
        end
        break;
      end
    end
    @(posedge clk); #1;
    drive(sel, m, 1'b0, we, addr, wd);
    check_vec({tag, "_ack_cycle"}, ack_cyc, 3 + sc);
    check_vec({tag, "_strobe_len"}, n_w, we ? sc : 0);
    if (we) check_vec({tag, "_strobe_start"}, first_w, 2);
    check_vec({tag, "_addr_stable"}, 32'(addr_ok), 1);
    check_vec({tag, "_grant"}, 32'(grant_ok), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_idx [4];
    int ack_cyc [4];
    int n_ack;
    int pending_idle;
    int stray_ack;

    in_pins = 8'h00;
    out_a = '0;
    out_b = '0;
    for (int i = 0; i < 128; i++) ram_a[i] = 1'b0;
    if_a.m_req = '0; if_a.m_we = '0; if_a.m_addr = '0; if_a.m_wdata = '0;
    if_b.m_req = '0; if_b.m_we = '0; if_b.m_addr = '0; if_b.m_wdata = '0;

    // Reset state
    @(posedge clk); #1;
    @(negedge clk);
    check_vec("rst_state", 32'(st_a), 32'(IDLE));
    check_vec("rst_io_write", 32'(if_a.io_write), 0);
    check_vec("rst_ack", 32'(if_a.m_ack), 0);
    check_vec("rst_grant", 32'(if_a.m_grant), 0);
    check_vec("rst_rdata", 32'(if_a.m_rdata), 0);
    check_vec("rst_addr", 32'(if_a.io_address), 0);
    check_vec("rst_b_state", 32'(st_b), 32'(IDLE));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Write to output latch 0
    access(0, 1, 0, 1'b1, 8'h80, 1'b1, 1'b0, "wr80");
    check_vec("wr80_latch", 32'(out_a[0]), 1);

    // RAM write then read-back by M1
    access(0, 1, 1, 1'b1, 8'h05, 1'b1, 1'b0, "wr05");
    access(0, 1, 1, 1'b0, 8'h05, 1'b0, 1'b1, "rd05_one");
    access(0, 1, 0, 1'b1, 8'h06, 1'b0, 1'b0, "wr06");
    check_vec("wr_keeps_rdata", 32'(if_a.m_rdata), 1);
    access(0, 1, 0, 1'b1, 8'h05, 1'b0, 1'b0, "wr05_zero");
    access(0, 1, 1, 1'b0, 8'h05, 1'b0, 1'b0, "rd05_zero");

    // Input-range write has no effect; unmapped read returns 0
    access(0, 1, 0, 1'b1, 8'h80 + OUTPUT_SIZE, 1'b1, 1'b0, "wr_inrange");
    check_vec("inrange_latches", 32'(out_a), 32'h01);
    access(0, 1, 1, 1'b0, 8'h80, 1'b0, 1'b1, "rd80");
    access(0, 1, 1, 1'b0, 8'hFF, 1'b0, 1'b0, "rdFF");
    access(0, 1, 0, 1'b0, 8'h80 + OUTPUT_SIZE, 1'b0, 1'b0, "rd_inpin");

    // Reset mid-STROBE of a write
    drive(0, 0, 1'b1, 1'b1, 8'h81, 1'b1);
    repeat (3) @(negedge clk);
    check_vec("midrst_strobe_up", 32'(if_a.io_write), 1);
    reset = 1'b1;
    drive(0, 0, 1'b0, 1'b1, 8'h81, 1'b1);
    @(negedge clk);
    check_vec("midrst_io_write", 32'(if_a.io_write), 0);
    check_vec("midrst_ack", 32'(if_a.m_ack), 0);
    check_vec("midrst_grant", 32'(if_a.m_grant), 0);
    check_vec("midrst_state", 32'(st_a), 32'(IDLE));
    repeat (2) @(negedge clk);
    @(posedge clk); #1 reset = 1'b0;
    stray_ack = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (if_a.m_ack != '0 || if_a.io_write) stray_ack++;
    end
    check_vec("midrst_no_ack", stray_ack, 0);
    check_vec("midrst_write_done", 32'(out_a[1]), 1);

    // Both masters requesting continuously from reset: grants alternate
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    drive(0, 0, 1'b1, 1'b0, 8'h05, 1'b0);
    drive(0, 1, 1'b1, 1'b0, 8'h05, 1'b0);
    n_ack = 0;
    pending_idle = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (pending_idle != 0) begin
        check_vec("rr_idle_grant", 32'(if_a.m_grant), 0);
        pending_idle = 0;
      end
      if (if_a.m_ack != '0) begin
        ack_idx[n_ack] = (if_a.m_ack == 2'b01) ? 0 : (if_a.m_ack == 2'b10) ? 1 : 99;
        ack_cyc[n_ack] = k;
        n_ack++;
        pending_idle = 1;
        if (n_ack == 4) break;
      end
    end
    @(posedge clk); #1;
    drive(0, 0, 1'b0, 1'b0, 8'h05, 1'b0);
    drive(0, 1, 1'b0, 1'b0, 8'h05, 1'b0);
    @(negedge clk);
    check_vec("rr_final_idle_grant", 32'(if_a.m_grant), 0);
    check_vec("rr_ack_count", n_ack, 4);
    for (int i = 0; i < n_ack; i++) check_vec($sformatf("rr_order%0d", i), ack_idx[i], i % 2);
    for (int i = 1; i < n_ack; i++) check_vec($sformatf("rr_gap%0d", i), ack_cyc[i] - ack_cyc[i-1], 5);

    // Three-cycle strobe instance
    @(posedge clk); #1;
    access(1, 3, 0, 1'b1, 8'h82, 1'b1, 1'b0, "sc3_wr82");
    check_vec("sc3_latch", 32'(out_b[2]), 1);
    access(1, 3, 1, 1'b0, 8'h10, 1'b0, 1'b0, "sc3_rd10");

    check_vec("exp_q_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
